// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit: state encodings,
// source-field layout, hold-counter width and the bundled control word.
package hazard_detection_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_HOLD = 1'b1
  } state_e;

  localparam int SRC_USED_BIT = 3;
  localparam int REG_IDX_W    = 3;
  localparam int HOLD_CNT_W   = 4;

  typedef struct packed {
    logic pc_write_en;
    logic fd_write_en;
    logic de_write_en;
    logic em_write_en;
    logic fd_flush;
    logic de_bubble;
    logic mw_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN  = '{pc_write_en: 1'b1, fd_write_en: 1'b1, de_write_en: 1'b1,
                                  em_write_en: 1'b1, fd_flush: 1'b0, de_bubble: 1'b0,
                                  mw_bubble: 1'b0};
  localparam ctrl_t CTRL_HOLD = '{pc_write_en: 1'b0, fd_write_en: 1'b0, de_write_en: 1'b0,
                                  em_write_en: 1'b0, fd_flush: 1'b0, de_bubble: 1'b0,
                                  mw_bubble: 1'b1};

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side signal bundle for the hazard detection unit: hazard sources in,
// stage enables / flush / bubble controls out.
interface hazard_detection_unit_if;
  import hazard_detection_unit_pkg::*;

  logic [SRC_USED_BIT:0]  fd_src_1_num;
  logic [SRC_USED_BIT:0]  fd_src_2_num;
  logic                   de_mem_read;
  logic                   de_reg_write;
  logic [REG_IDX_W-1:0]   de_reg_dst_num;
  logic                   de_long_mem;
  logic                   branch_taken;

  logic                   pc_write_en;
  logic                   fd_write_en;
  logic                   de_write_en;
  logic                   em_write_en;
  logic                   fd_flush;
  logic                   de_bubble;
  logic                   mw_bubble;

  modport master (
    output fd_src_1_num, fd_src_2_num, de_mem_read, de_reg_write,
           de_reg_dst_num, de_long_mem, branch_taken,
    input  pc_write_en, fd_write_en, de_write_en, em_write_en,
           fd_flush, de_bubble, mw_bubble
  );

  modport slave (
    input  fd_src_1_num, fd_src_2_num, de_mem_read, de_reg_write,
           de_reg_dst_num, de_long_mem, branch_taken,
    output pc_write_en, fd_write_en, de_write_en, em_write_en,
           fd_flush, de_bubble, mw_bubble
  );
endinterface

// File: rtl/hazard_detection_unit_reg_match.sv
// reg_match: flags a decode-stage source that is in use and names the given
// destination register.
module hazard_detection_unit_reg_match
  import hazard_detection_unit_pkg::*;
(
  input  logic [SRC_USED_BIT:0] src_num_i,
  input  logic [REG_IDX_W-1:0]  dst_num_i,
  output logic                  hit_o
);

  assign hit_o = src_num_i[SRC_USED_BIT] & (src_num_i[REG_IDX_W-1:0] == dst_num_i);

endmodule

// File: rtl/hazard_detection_unit.sv
// Five-stage pipeline hazard control: load-use bubble, taken-branch flush and
// multi-cycle freeze for two-word memory accesses.
// Optional macro HAZARD_PERF_CNT_EN adds a saturating stall_cycles counter.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned MEM_EXTRA_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_detection_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(MEM_EXTRA_CYCLES);
  localparam logic [HOLD_CNT_W-1:0] CNT_ONE   = HOLD_CNT_W'(1);

  state_e                state_q, state_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  hit_1, hit_2, load_use;
  ctrl_t                 ctrl;

  hazard_detection_unit_reg_match u_match_1 (
    .src_num_i (hz.fd_src_1_num),
    .dst_num_i (hz.de_reg_dst_num),
    .hit_o     (hit_1)
  );

  hazard_detection_unit_reg_match u_match_2 (
    .src_num_i (hz.fd_src_2_num),
    .dst_num_i (hz.de_reg_dst_num),
    .hit_o     (hit_2)
  );

  assign load_use = hz.de_mem_read & hz.de_reg_write & (hit_1 | hit_2);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_RUN;
    unique case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          ctrl.fd_flush  = 1'b1;
          ctrl.de_bubble = 1'b1;
        end else if (load_use) begin
          ctrl.pc_write_en = 1'b0;
          ctrl.fd_write_en = 1'b0;
          ctrl.de_bubble   = 1'b1;
        end
        if (hz.de_long_mem) begin
          state_d = MEM_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      MEM_HOLD: begin
        ctrl  = CTRL_HOLD;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Reset forces the free-running defaults regardless of state or inputs.
    if (reset) ctrl = CTRL_RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_write_en = ctrl.pc_write_en;
  assign hz.fd_write_en = ctrl.fd_write_en;
  assign hz.de_write_en = ctrl.de_write_en;
  assign hz.em_write_en = ctrl.em_write_en;
  assign hz.fd_flush    = ctrl.fd_flush;
  assign hz.de_bubble   = ctrl.de_bubble;
  assign hz.mw_bubble   = ctrl.mw_bubble;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset)                                     stall_q <= '0;
    else if (!ctrl.pc_write_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed self-checking bench for hazard_detection_unit with MEM_EXTRA_CYCLES=3.
module tb_hazard_detection_unit;
  import hazard_detection_unit_pkg::*;

  localparam logic [6:0] DEF   = 7'b1111_000;
  localparam logic [6:0] STALL = 7'b0011_010;
  localparam logic [6:0] FLUSH = 7'b1111_110;
  localparam logic [6:0] HOLD  = 7'b0000_001;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  hazard_detection_unit_if u_if ();

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  hazard_detection_unit #(.MEM_EXTRA_CYCLES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (u_if.slave)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic mr,
                       input logic rw, input logic [2:0] dst, input logic lm, input logic br);
    u_if.fd_src_1_num   = s1;
    u_if.fd_src_2_num   = s2;
    u_if.de_mem_read    = mr;
    u_if.de_reg_write   = rw;
    u_if.de_reg_dst_num = dst;
    u_if.de_long_mem    = lm;
    u_if.branch_taken   = br;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    #1;
    check(tag, {25'd0, u_if.pc_write_en, u_if.fd_write_en, u_if.de_write_en,
                u_if.em_write_en, u_if.fd_flush, u_if.de_bubble, u_if.mw_bubble},
          {25'd0, exp});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic load_use_in();
    drive(4'b0000, 4'b1101, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    load_use_in();
    u_if.branch_taken = 1'b1;
    @(negedge clk);
    chk_out("reset_defaults", DEF);
    step();
    reset = 1'b0;
    idle();
    chk_out("idle", DEF);

    load_use_in();
    chk_out("lu_src2", STALL);
    step();
    idle();
    chk_out("lu_cleared", DEF);
    step();
    drive(4'b1101, 4'b0000, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    chk_out("lu_src1", STALL);
    step();
    drive(4'b0000, 4'b0101, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    chk_out("lu_unused_src", DEF);
    step();
    drive(4'b0000, 4'b1101, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
    chk_out("lu_no_regwrite", DEF);
    step();
    drive(4'b0000, 4'b1101, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    chk_out("lu_no_memread", DEF);
    step();
    drive(4'b1100, 4'b1110, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    chk_out("lu_other_reg", DEF);
    step();

    load_use_in();
    u_if.branch_taken = 1'b1;
    chk_out("branch_and_lu", FLUSH);
    step();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk_out("branch_only", FLUSH);
    step();

    // Single long access; hazards raised during the hold must be ignored.
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_out("lm_issue", DEF);
    step();
    load_use_in();
    u_if.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("lm_hold%0d", i), HOLD);
      step();
    end
    idle();
    chk_out("lm_release", DEF);
    step();

    // Long access coinciding with a load-use stall.
    load_use_in();
    u_if.de_long_mem = 1'b1;
    chk_out("lm_with_lu", STALL);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("lm_lu_hold%0d", i), HOLD);
      step();
    end
    chk_out("lm_lu_release", DEF);
    step();

    // Back-to-back long accesses each get a full hold.
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_out("b2b_issue1", DEF);
    step();
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("b2b_hold_a%0d", i), HOLD);
      step();
    end
    chk_out("b2b_issue2", DEF);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("b2b_hold_b%0d", i), HOLD);
      step();
    end
    chk_out("b2b_release", DEF);
    step();

    // Reset in the second hold cycle aborts the hold.
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_out("rst_issue", DEF);
    step();
    idle();
    chk_out("rst_hold1", HOLD);
    step();
    reset = 1'b1;
    chk_out("rst_during_hold", DEF);
    step();
    reset = 1'b0;
    chk_out("rst_after", DEF);
    check("rst_cnt_zero", {28'd0, dut.cnt_q}, 32'd0);
    step();
    chk_out("rst_after2", DEF);

`ifdef HAZARD_PERF_CNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("perf_reset", {16'd0, stall_cycles}, 32'd0);
    load_use_in();
    step();
    idle();
    step();
    load_use_in();
    step();
    idle();
    u_if.de_long_mem = 1'b1;
    step();
    idle();
    repeat (3) step();
    #1;
    check("perf_five", {16'd0, stall_cycles}, 32'd5);
    load_use_in();
    repeat (65540) @(negedge clk);
    #1;
    check("perf_saturate", {16'd0, stall_cycles}, 32'h0000FFFF);
    step();
    #1;
    check("perf_hold_sat", {16'd0, stall_cycles}, 32'h0000FFFF);
    idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline control block that reads the decode/execute pipeline-register outputs and the fetch/decode source fields, and issues the hold, bubble and flush controls for the five-stage pipeline. It inserts one bubble on a load-use dependency, flushes the two younger stages on a taken branch, and freezes the pipeline for a fixed number of extra cycles while a two-word memory access occupies the memory stage.

## Interface
- MEM_EXTRA_CYCLES, 1: extra memory-stage cycles for a two-word access; legal range 1..15.
- clk  in  1  pipeline clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fd_src_1_num  in  4  decode-stage source 1; bit 3 = register used, bits 2:0 = register index.
- fd_src_2_num  in  4  decode-stage source 2; same layout.
- de_mem_read  in  1  DE control: instruction in execute reads memory.
- de_reg_write  in  1  DE control: instruction in execute writes a register.
- de_reg_dst_num  in  3  DE destination register index.
- de_long_mem  in  1  DE control: two-word memory access.
- branch_taken  in  1  execute-stage resolved taken branch.
- pc_write_en, fd_write_en, de_write_en, em_write_en  out  1 each  register enables; 1 = load.
- fd_flush  out  1  load a NOP into FD.
- de_bubble  out  1  load zero control signals into DE.
- mw_bubble  out  1  load zero control signals into MW.

## Operation
- States: RUN, MEM_HOLD. A 4-bit hold counter runs alongside.
- load_use = de_mem_read & de_reg_write & ((fd_src_1_num[3] & fd_src_1_num[2:0]==de_reg_dst_num) | (fd_src_2_num[3] & fd_src_2_num[2:0]==de_reg_dst_num)).
- RUN defaults: all four enables 1; flush and bubble outputs 0.
- RUN with branch_taken:
  - fd_flush=1, de_bubble=1. The PC is loaded with the target, so pc_write_en=1.
  - load_use is ignored in that cycle.
- RUN with load_use and no branch:
  - pc_write_en=0, fd_write_en=0, de_bubble=1. This is one bubble only.
  - The next cycle sees the bubble in DE, so load_use clears.
- RUN with de_long_mem (independent of the two cases above):
  - Next state is MEM_HOLD, counter loaded with MEM_EXTRA_CYCLES.
  - The current cycle's outputs are unchanged.
- MEM_HOLD:
  - All four enables 0, mw_bubble=1, fd_flush=0, de_bubble=0.
  - branch_taken and load_use are ignored. Their source instructions are frozen, so they are re-evaluated on return to RUN.
  - The counter decrements each cycle. When it is 1, the next state is RUN.
- Reset:
  - State RUN, counter 0.
  - While reset is high, outputs take the RUN defaults.
  - Reset during MEM_HOLD aborts the hold; the next cycle is RUN.

## Timing
- load_use, branch and RUN outputs are Mealy: combinational from inputs, same cycle, zero latency.
- MEM_HOLD outputs are Moore, decoded from state only.
- A de_long_mem instruction sampled at edge E0 enters EM at E0. The pipeline is then frozen for exactly MEM_EXTRA_CYCLES cycles. The first RUN cycle lets EM advance into MW.
- Back-to-back de_long_mem instructions:
  - Each gets its own full hold.
  - The second is only sampled in the first RUN cycle after the first hold.
- Branch and load_use in the same RUN cycle: the branch wins, and no PC hold occurs.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds output port stall_cycles (16 bits, out).
  - It counts cycles with pc_write_en==0 while reset is low and saturates at 16'hFFFF.
  - reset clears it to 0.
- HAZARD_PERF_CNT_EN undefined: the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- The shared pipeline package holds:
  - the state encodings (RUN=1'b0, MEM_HOLD=1'b1);
  - SRC_USED_BIT=3 and the register-index width 3;
  - the hold-counter width 4.
- One sub-module, reg_match. It takes a 4-bit source field and a 3-bit destination and returns a 1-bit hit. It is instantiated twice.
- The FSM, counter and output decode live in the top level.

## Test plan
- load-use:
  - Stimulus: de_mem_read=1, de_reg_write=1, de_reg_dst_num=3'd5, fd_src_2_num=4'b1101.
  - Response, same cycle: pc_write_en=0, fd_write_en=0, de_bubble=1.
  - Response, next cycle with DE zeroed: all enables 1.
- Unused source: the same case with fd_src_2_num=4'b0101 produces no stall, since bit 3 is clear.
- Branch with load_use both high: fd_flush=1, de_bubble=1, pc_write_en=1.
- de_long_mem=1 for one cycle with MEM_EXTRA_CYCLES=3:
  - The next 3 cycles show all enables 0 and mw_bubble=1.
  - Cycle 4 is RUN defaults.
- Reset asserted in the 2nd MEM_HOLD cycle: the next cycle shows RUN defaults and the counter is 0.
- HAZARD_PERF_CNT_EN:
  - 2 load-use stalls plus one hold of 3 give stall_cycles=5.
  - Preloading near 16'hFFFF and stalling confirms saturation.
